uart_frame_loader: RTL

//  Receives pixel packets on the uart_rx pin and writes 18-bit RGB pixels into the framebuffer write port.

---
 rtl/uart_frame_loader_pkg.sv | 38 +++
 rtl/uart_frame_loader_uart_rx_byte.sv | 103 ++++++++++
 rtl/uart_frame_loader.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/uart_frame_loader_pkg.sv
// Shared constants and types for the UART pixel loader.
//   Panel geometry, colour depth, packet sync marker, derived address widths,
//   receiver and packet FSM state types, and the colour-extraction helper.
package uart_frame_loader_pkg;

    localparam int unsigned COLUMNS    = 64;
    localparam int unsigned ROWS       = 32;
    localparam int unsigned COLOR_BITS = 6;
    localparam logic [7:0]  SYNC_BYTE  = 8'hA5;

    localparam int unsigned COL_W  = $clog2(COLUMNS);
    localparam int unsigned ROW_W  = $clog2(ROWS);
    localparam int unsigned ADDR_W = ROW_W + COL_W;
    localparam int unsigned DATA_W = 3 * COLOR_BITS;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROW,
        ST_COL,
        ST_COUNT,
        ST_RED,
        ST_GREEN,
        ST_BLUE
    } pkt_state_t;

    // Sub-pixel value is the top COLOR_BITS of the received byte.
    function automatic logic [COLOR_BITS-1:0] color_of(input logic [7:0] b);
        return b[7 -: COLOR_BITS];
    endfunction

endpackage

// File: rtl/uart_frame_loader_uart_rx_byte.sv
// 8N1 UART byte receiver.
//   clk_in      : system clock
//   reset       : asynchronous active-high reset
//   uart_rx     : raw line, idle high, asynchronous to clk_in
//   data        : last received byte (valid while byte_valid is high, held after)
//   byte_valid  : one-cycle pulse, stop bit was 1
//   framing_err : one-cycle pulse, stop bit was 0 (byte discarded)
module uart_rx_byte
    import uart_frame_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 61
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       framing_err
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

    logic          sync1, sync2;
    rx_state_t     state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          valid_n, ferr_n;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            // Synchroniser resets to the idle line level so release never looks like a start bit.
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            state       <= RX_IDLE;
            timer       <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            byte_valid  <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            sync1       <= uart_rx;
            sync2       <= sync1;
            state       <= state_n;
            timer       <= timer_n;
            bit_idx     <= bit_idx_n;
            shift       <= shift_n;
            byte_valid  <= valid_n;
            framing_err <= ferr_n;
        end
    end

    always_comb begin
        state_n   = state;
        timer_n   = timer;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
        case (state)
            RX_IDLE: begin
                timer_n = '0;
                if (!sync2) state_n = RX_START;
            end
            RX_START: begin
                if (timer == HALF_M1) begin
                    timer_n   = '0;
                    bit_idx_n = '0;
                    // Line back high at mid start bit: a glitch, not a frame.
                    state_n   = sync2 ? RX_IDLE : RX_DATA;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            RX_DATA: begin
                if (timer == FULL_M1) begin
                    timer_n = '0;
                    shift_n = {sync2, shift[7:1]};
                    if (bit_idx == 3'd7) state_n = RX_STOP;
                    else bit_idx_n = bit_idx + 1'b1;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            RX_STOP: begin
                if (timer == FULL_M1) begin
                    timer_n = '0;
                    state_n = RX_IDLE;
                    if (sync2) valid_n = 1'b1;
                    else ferr_n = 1'b1;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

    assign data = shift;

endmodule

// File: rtl/uart_frame_loader.sv
// UART packet to framebuffer pixel writer.
//   clk_in     : system clock
//   reset      : asynchronous active-high reset
//   uart_rx    : raw UART line (8N1, idle high)
//   fb_wr_en   : one-cycle framebuffer write strobe
//   fb_wr_addr : {row, col}
//   fb_wr_data : {red, green, blue}, red in MSBs
//   frame_done : pulse with the last pixel write of a packet
//   rx_error   : pulse on framing error, timeout or out-of-range header
//   busy       : high while a packet is being parsed
// Packet: SYNC_BYTE, ROW, COL, COUNT, COUNT x (R, G, B); COUNT=0 means 256.
module uart_frame_loader
    import uart_frame_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 61,
    parameter int unsigned TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              uart_rx,
    output logic              fb_wr_en,
    output logic [ADDR_W-1:0] fb_wr_addr,
    output logic [DATA_W-1:0] fb_wr_data,
    output logic              frame_done,
    output logic              rx_error,
    output logic              busy
);

    localparam int unsigned TCW = $clog2(TIMEOUT_CLKS + 1);

    logic [7:0] rx_data;
    logic       byte_valid, framing_err;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_in      (clk_in),
        .reset       (reset),
        .uart_rx     (uart_rx),
        .data        (rx_data),
        .byte_valid  (byte_valid),
        .framing_err (framing_err)
    );

    pkt_state_t            state, state_n;
    logic [ROW_W-1:0]      row;
    logic [COL_W-1:0]      col;
    logic [7:0]            remaining;
    logic [COLOR_BITS-1:0] red, green;
    logic [TCW-1:0]        tcnt;
    logic                  timeout_hit;
    logic                  wr_n, done_n, err_n;

    assign timeout_hit = (tcnt == TCW'(TIMEOUT_CLKS - 1));
    assign busy        = (state != ST_IDLE);

    always_comb begin
        state_n = state;
        wr_n    = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        if (framing_err) begin
            err_n   = 1'b1;
            state_n = ST_IDLE;
        end else if (byte_valid) begin
            // A byte arriving on the timeout cycle is consumed; the timeout is ignored.
            case (state)
                ST_IDLE:  if (rx_data == SYNC_BYTE) state_n = ST_ROW;
                ST_ROW: begin
                    if (int'(rx_data) >= ROWS) begin
                        err_n   = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_COL;
                    end
                end
                ST_COL: begin
                    if (int'(rx_data) >= COLUMNS) begin
                        err_n   = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_COUNT;
                    end
                end
                ST_COUNT: state_n = ST_RED;
                ST_RED:   state_n = ST_GREEN;
                ST_GREEN: state_n = ST_BLUE;
                ST_BLUE: begin
                    wr_n = 1'b1;
                    // COUNT=0 decrements through 255 and so yields 256 pixels.
                    if (remaining == 8'd1) begin
                        done_n  = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_RED;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end else if (state != ST_IDLE && timeout_hit) begin
            err_n   = 1'b1;
            state_n = ST_IDLE;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            fb_wr_en   <= 1'b0;
            fb_wr_addr <= '0;
            fb_wr_data <= '0;
            frame_done <= 1'b0;
            rx_error   <= 1'b0;
            row        <= '0;
            col        <= '0;
            remaining  <= '0;
            red        <= '0;
            green      <= '0;
            tcnt       <= '0;
        end else begin
            state      <= state_n;
            fb_wr_en   <= wr_n;
            frame_done <= done_n;
            rx_error   <= err_n;

            if (byte_valid || state == ST_IDLE) tcnt <= '0;
            else tcnt <= tcnt + 1'b1;

            if (byte_valid) begin
                case (state)
                    ST_ROW:   row       <= rx_data[ROW_W-1:0];
                    ST_COL:   col       <= rx_data[COL_W-1:0];
                    ST_COUNT: remaining <= rx_data;
                    ST_RED:   red       <= color_of(rx_data);
                    ST_GREEN: green     <= color_of(rx_data);
                    default: ;
                endcase
            end

            if (wr_n) begin
                fb_wr_addr <= {row, col};
                fb_wr_data <= {red, green, color_of(rx_data)};
                remaining  <= remaining - 1'b1;
                if (col == COL_W'(COLUMNS - 1)) begin
                    col <= '0;
                    row <= (row == ROW_W'(ROWS - 1)) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule
